// File: rtl/ifid_bubble_reg_pkg.sv
// Shared pipeline definitions for the IF/ID register: state encodings,
// the bubble instruction word and default datapath widths.
package ifid_bubble_reg_pkg;

  localparam int          PC_W_DEF = 32;
  localparam int          IR_W_DEF = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Encodes where the current register contents came from on the last update.
  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_STALL = 2'b01,
    S_BUB   = 2'b10
  } state_t;

endpackage

// File: rtl/ifid_bubble_reg_if.sv
// Fetch-to-decode bus: fetch-side request/data toward the IF/ID register and
// the registered slot it presents to decode.
interface ifid_bubble_reg_if
  import ifid_bubble_reg_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int IR_W = IR_W_DEF
) ();

  logic            j_bub;
  logic            stall;
  logic [PC_W-1:0] pc_in;
  logic [IR_W-1:0] ir_in;
  logic [PC_W-1:0] pc_out;
  logic [IR_W-1:0] ir_out;
  logic            valid_out;

  modport master (
    output j_bub, stall, pc_in, ir_in,
    input  pc_out, ir_out, valid_out
  );

  modport slave (
    input  j_bub, stall, pc_in, ir_in,
    output pc_out, ir_out, valid_out
  );

endinterface

// File: rtl/ifid_bubble_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a run enable;
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en && inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ifid_bubble_reg.sv
// IF/ID pipeline register: inserts a NOP bubble on flush, holds on load-use
// stall, otherwise loads the fetched PC/IR; keeps saturating statistics.
module ifid_bubble_reg
  import ifid_bubble_reg_pkg::*;
#(
  parameter int              PC_W  = PC_W_DEF,
  parameter int              IR_W  = IR_W_DEF,
  parameter logic [IR_W-1:0] NOP   = IR_W'(NOP_WORD),
  parameter int              CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  ifid_bubble_reg_if.slave    bus,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    redirect_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  state_t state_q;
  state_t state_d;
  logic   do_bub;
  logic   do_stall;
  logic   do_load;
  logic   j_hist;
  logic   redirect_inc;

  // State register: en==0 freezes the debug state along with everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_BUB;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // Next state: flush beats stall, from any state.
  always_comb begin
    // NOTE: a default on every path keeps combinational blocks latch-free.
    state_d = state_q;
    if (bus.j_bub) begin
      state_d = S_BUB;
    end else if (bus.stall) begin
      state_d = S_STALL;
    end else begin
      state_d = S_RUN;
    end
  end

  // Action decode driving the datapath and the statistics counters.
  always_comb begin
    do_bub   = 1'b0;
    do_stall = 1'b0;
    do_load  = 1'b0;
    if (en) begin
      do_bub   = bus.j_bub;
      do_stall = !bus.j_bub && bus.stall;
      do_load  = !bus.j_bub && !bus.stall;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.pc_out    <= '0;
      bus.ir_out    <= NOP;
      bus.valid_out <= 1'b0;
      j_hist        <= 1'b0;
    end else begin
      // The edge detector only advances on enabled cycles so a halt cannot
      // hide or fabricate a redirect.
      if (en) begin
        j_hist <= bus.j_bub;
      end
      if (do_bub) begin
        bus.pc_out    <= bus.pc_in;
        bus.ir_out    <= NOP;
        bus.valid_out <= 1'b0;
      end else if (do_load) begin
        bus.pc_out    <= bus.pc_in;
        bus.ir_out    <= bus.ir_in;
        bus.valid_out <= 1'b1;
      end
    end
  end

  assign redirect_inc = bus.j_bub && !j_hist;
  assign state        = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .inc   (bus.j_bub),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .inc   (redirect_inc),
    .count (redirect_cnt)
  );

  // A stall that coincides with a flush is on the wrong path and not counted.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .inc   (bus.stall && !bus.j_bub),
    .count (stall_cnt)
  );

endmodule
